// File: rtl/htif_pkg.sv
// rtl/htif_pkg.sv - shared constants and FSM state type for the tohost/fromhost responder
package htif_pkg;
  localparam logic [3:0]  DEV_SYS  = 4'h0;
  localparam logic [3:0]  DEV_CON  = 4'h1;
  localparam logic [3:0]  CMD_GETC = 4'h0;
  localparam logic [3:0]  CMD_PUTC = 4'h1;
  localparam logic [23:0] RESP_ERR = 24'hFFFFFF;
  localparam logic [23:0] RESP_OK  = 24'h000001;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    PUTC_WAIT = 3'd2,
    RESP      = 3'd3,
    HALT      = 3'd4
  } state_t;
endpackage

// File: rtl/htif_if.sv
// rtl/htif_if.sv - mailbox, console and exit signals between the core side and the host responder
interface htif_if;
  logic        tohost_we;
  logic [31:0] tohost;
  logic        fromhost_we;
  logic [31:0] fromhost;
  logic        busy;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        exit_valid;
  logic [30:0] exit_code;
  logic        pass;
  logic        halted;
  logic        err;

  modport slave (
    input  tohost_we, tohost, con_ready, rx_valid, rx_data,
    output fromhost_we, fromhost, busy, con_valid, con_data, rx_ready,
           exit_valid, exit_code, pass, halted, err
  );

  modport master (
    output tohost_we, tohost, con_ready, rx_valid, rx_data,
    input  fromhost_we, fromhost, busy, con_valid, con_data, rx_ready,
           exit_valid, exit_code, pass, halted, err
  );
endinterface

// File: rtl/htif_fifo.sv
// rtl/htif_fifo.sv - console output byte FIFO, registered count, no write-to-read bypass
module htif_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  output logic       full_o,
  output logic       valid_o,
  output logic [7:0] data_o,
  input  logic       ready_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop;

  // Full is judged on the start-of-cycle count, so a same-cycle pop never frees a slot early
  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop     = valid_o && ready_i;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/htif_host.sv
// rtl/htif_host.sv - decodes tohost writes into exit/putchar/getchar and answers on fromhost
module htif_host
  import htif_pkg::*;
#(
  parameter int CON_DEPTH = 4
) (
  input logic   CLK,
  input logic   RSTn,
  htif_if.slave bus
);
  state_t      state_q, state_d;
  logic [31:0] word_q, word_d, resp_q, resp_d;
  logic [30:0] exit_code_q, exit_code_d;
  logic        exit_valid_q, exit_valid_d;
  logic        pass_q, pass_d, halted_q, halted_d, err_q, err_d;
  logic        push, full, rx_pop;

  logic [3:0] dev, cmd;
  logic       is_exit, is_putc, is_getc;

  assign dev     = word_q[31:28];
  assign cmd     = word_q[27:24];
  assign is_exit = (dev == DEV_SYS) && word_q[0];
  assign is_putc = (dev == DEV_CON) && (cmd == CMD_PUTC);
  assign is_getc = (dev == DEV_CON) && (cmd == CMD_GETC);

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    resp_d       = resp_q;
    exit_code_d  = exit_code_q;
    exit_valid_d = 1'b0;
    pass_d       = pass_q;
    halted_d     = halted_q;
    err_d        = err_q;
    push         = 1'b0;
    rx_pop       = 1'b0;
    // Writes while a command is in flight are dropped; HALT drops them without complaint
    if (bus.tohost_we && state_q != IDLE && state_q != HALT) err_d = 1'b1;
    case (state_q)
      IDLE: if (bus.tohost_we) begin
        word_d  = bus.tohost;
        state_d = DECODE;
      end
      DECODE: begin
        if (is_exit) begin
          exit_valid_d = 1'b1;
          halted_d     = 1'b1;
          exit_code_d  = word_q[31:1];
          pass_d       = pass_q | (word_q == 32'h0000_0001);
          state_d      = HALT;
        end else if (is_putc) begin
          state_d = PUTC_WAIT;
        end else if (is_getc) begin
          rx_pop  = bus.rx_valid;
          resp_d  = bus.rx_valid ? {DEV_CON, CMD_GETC, 16'h0, bus.rx_data}
                                 : {DEV_CON, CMD_GETC, RESP_ERR};
          state_d = RESP;
        end else begin
          err_d   = 1'b1;
          resp_d  = {dev, cmd, RESP_ERR};
          state_d = RESP;
        end
      end
      PUTC_WAIT: if (!full) begin
        push    = 1'b1;
        resp_d  = {DEV_CON, CMD_PUTC, RESP_OK};
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      word_q       <= '0;
      resp_q       <= '0;
      exit_code_q  <= '0;
      exit_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      resp_q       <= resp_d;
      exit_code_q  <= exit_code_d;
      exit_valid_q <= exit_valid_d;
      pass_q       <= pass_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
    end
  end

  htif_fifo #(.DEPTH(CON_DEPTH)) u_con_fifo (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .push_i      (push),
    .push_data_i (word_q[7:0]),
    .full_o      (full),
    .valid_o     (bus.con_valid),
    .data_o      (bus.con_data),
    .ready_i     (bus.con_ready)
  );

  assign bus.fromhost_we = (state_q == RESP);
  assign bus.fromhost    = resp_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.rx_ready    = rx_pop;
  assign bus.exit_valid  = exit_valid_q;
  assign bus.exit_code   = exit_code_q;
  assign bus.pass        = pass_q;
  assign bus.halted      = halted_q;
  assign bus.err         = err_q;
endmodule

// File: doc/htif_host.md
# htif_host

Host-side responder for the core's tohost/fromhost mailbox. It captures each 32-bit tohost write and decodes it into one of three actions: an exit report, a console putchar, or a console getchar. It returns an acknowledge word on fromhost. It sits beside the core in simulation tops and FPGA shells, and it drives exit status and a byte-stream console.

## Interface
- CON_DEPTH, 4, console output FIFO depth in entries; power of 2, ≥2.
- CLK  in  1  clock.
- RSTn  in  1  reset, asynchronous, active-low.
- tohost_we  in  1  one-cycle write strobe from core.
- tohost  in  32  command word: [31:28] dev, [27:24] cmd, [23:0] payload.
- fromhost_we  out  1  one-cycle response strobe.
- fromhost  out  32  response word, valid when fromhost_we.
- busy  out  1  a command is in flight; core must not write.
- con_valid / con_data[7:0] / con_ready  out/out/in  console output stream.
- rx_valid / rx_data[7:0]  in  console input byte available.
- rx_ready  out  1  one-cycle pop of the rx byte.
- exit_valid  out  1  one-cycle pulse on exit command.
- exit_code  out  31  tohost[31:1] of the exit command, held after exit.
- pass  out  1  sticky; set when the exit word equals 32'h0000_0001.
- halted  out  1  sticky after exit.
- err  out  1  sticky; set on unknown command or overrun.

## Operation
- Exit: dev=0 and tohost[0]=1.
  - exit_code is tohost[31:1].
  - pass is set when tohost==1.
  - No fromhost response.
  - Enters HALT.
- Putchar: dev=1, cmd=1. Pushes tohost[7:0] into the FIFO, then responds {4'h1,4'h1,24'h000001}.
- Getchar: dev=1, cmd=0.
  - If rx_valid: pulse rx_ready and respond {4'h1,4'h0,16'h0,rx_data}.
  - Otherwise respond {4'h1,4'h0,24'hFFFFFF}.
- Anything else, including dev=0 with tohost[0]=0: set err and respond {dev,cmd,24'hFFFFFF}. The core is never left waiting.
- Overrun: tohost_we while busy or halted.
  - The write is dropped and err is set.
  - In HALT, writes are dropped silently and err is not set.
- FSM states:
  - IDLE: on tohost_we, latch the word and go to DECODE.
  - DECODE: branch to RESP, PUTC_WAIT, or HALT.
  - PUTC_WAIT: push when the FIFO is not full, then go to RESP.
  - RESP: pulse fromhost_we, return to IDLE.
  - HALT: terminal until reset.
- busy = (state != IDLE). busy is set the cycle after tohost_we.
- All outputs reset to 0. Reset mid-command discards the latched word and empties the FIFO.

## Timing
- tohost_we in cycle N:
  - DECODE in N+1.
  - fromhost_we in N+2 for getchar and unknown commands.
  - fromhost_we in N+3 for putchar with a non-full FIFO: push in N+2, RESP in N+3.
- Exit: exit_valid and halted asserted in N+2.
- rx_ready is pulsed in the DECODE cycle; rx_data is sampled in that same cycle.
- FIFO rules:
  - Push is allowed only when count<CON_DEPTH at the start of the cycle.
  - A pop by con_valid&con_ready in the same cycle as a full condition does not permit the push; the push happens the following cycle.
  - No bypass: con_valid rises the cycle after a push into an empty FIFO.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo CON_DEPTH. Count is $clog2(CON_DEPTH)+1 bits wide.
- Draining: con_valid and con_data hold until con_ready. The FIFO keeps draining in HALT.

## Structure
- Package htif_pkg contains:
  - DEV_SYS=4'h0, DEV_CON=4'h1, CMD_GETC=4'h0, CMD_PUTC=4'h1.
  - RESP_ERR=24'hFFFFFF.
  - typedef enum state_t {IDLE, DECODE, PUTC_WAIT, RESP, HALT}.
- Sub-module htif_fifo: CON_DEPTH×8 synchronous FIFO with push/full and valid/ready pop sides, reset via RSTn.

## Test plan
- Write 32'h0000_0001 → exit_valid pulses 2 cycles later; pass=1, halted=1, exit_code=0, no fromhost_we.
- Write 32'h0000_000B → exit_code=5, pass=0; a later write 32'h1100_0041 is dropped, err stays 0.
- Write 32'h1100_0048, then after its response 32'h1100_0069, with con_ready=1 → console bytes 0x48, 0x69 in order; each fromhost=32'h1100_0001, 3 cycles after its write.
- CON_DEPTH=4, con_ready=0, five putchars → the fifth stalls in PUTC_WAIT with busy high; one con_ready pulse yields 0x… head byte, then the fifth response follows.
- Getchar with rx_valid=1, rx_data=8'h7A → fromhost=32'h1000_007A, rx_ready for one cycle. Getchar with rx_valid=0 → fromhost=32'h10FF_FFFF.
- Write 32'h2300_0000 → err=1, fromhost=32'h23FF_FFFF. A second tohost_we while busy → dropped, only one fromhost_we. Assert RSTn low mid-PUTC_WAIT → all outputs 0, FIFO empty.
